// File: rtl/ctrl_pkg.sv
// ==========================================================================
// ctrl_pkg: shared state, opcode, ALU-code and mux encodings (rev 1.0)
// ==========================================================================
`default_nettype none

package ctrl_pkg;

  typedef enum logic [3:0] {
    S_IDLE     = 4'd0,
    S_FETCH    = 4'd1,
    S_DECODE   = 4'd2,
    S_MEMADR   = 4'd3,
    S_MEMREAD  = 4'd4,
    S_MEMWB    = 4'd5,
    S_MEMWRITE = 4'd6,
    S_EXECUTER = 4'd7,
    S_EXECUTEI = 4'd8,
    S_ALUWB    = 4'd9,
    S_BRANCH   = 4'd10,
    S_JAL      = 4'd11,
    S_TRAP     = 4'd12
  } state_t;

  localparam logic [2:0] ALU_ADD = 3'b000;
  localparam logic [2:0] ALU_SUB = 3'b001;
  localparam logic [2:0] ALU_AND = 3'b010;
  localparam logic [2:0] ALU_OR  = 3'b011;
  localparam logic [2:0] ALU_XOR = 3'b100;
  localparam logic [2:0] ALU_SLL = 3'b101;
  localparam logic [2:0] ALU_SRL = 3'b110;
  localparam logic [2:0] ALU_SLT = 3'b111;

  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_RTYPE  = 7'b0110011;
  localparam logic [6:0] OP_ITYPE  = 7'b0010011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_JAL    = 7'b1101111;

  localparam logic [1:0] SRCA_PC    = 2'b00;
  localparam logic [1:0] SRCA_OLDPC = 2'b01;
  localparam logic [1:0] SRCA_RS1   = 2'b10;

  localparam logic [1:0] SRCB_RS2  = 2'b00;
  localparam logic [1:0] SRCB_IMM  = 2'b01;
  localparam logic [1:0] SRCB_FOUR = 2'b10;

  localparam logic [1:0] RES_ALUOUT    = 2'b00;
  localparam logic [1:0] RES_DATA      = 2'b01;
  localparam logic [1:0] RES_ALURESULT = 2'b10;

  localparam logic [1:0] IMM_I = 2'b00;
  localparam logic [1:0] IMM_S = 2'b01;
  localparam logic [1:0] IMM_B = 2'b10;
  localparam logic [1:0] IMM_J = 2'b11;

  function automatic logic [1:0] imm_src_of(input logic [6:0] op);
    case (op)
      OP_STORE:  return IMM_S;
      OP_BRANCH: return IMM_B;
      OP_JAL:    return IMM_J;
      default:   return IMM_I;
    endcase
  endfunction

endpackage

`default_nettype wire

// File: rtl/alu_func_decode.sv
// ==========================================================================
// alu_func_decode: (op, funct3, funct7b5) -> ALU code + legal flag (rev 1.0)
// ==========================================================================
`default_nettype none

module alu_func_decode
  import ctrl_pkg::*;
(
  input  logic [6:0] op,
  input  logic [2:0] funct3,
  input  logic       funct7b5,
  output logic [2:0] alu_control,
  output logic       legal
);

  always_comb begin
    alu_control = ALU_ADD;
    legal       = 1'b1;
    case (funct3)
      3'b000: alu_control = (op == OP_RTYPE && funct7b5) ? ALU_SUB : ALU_ADD;
      3'b111: alu_control = ALU_AND;
      3'b110: alu_control = ALU_OR;
      3'b100: alu_control = ALU_XOR;
      3'b001: alu_control = ALU_SLL;
      3'b010: alu_control = ALU_SLT;
      // sra/srai has no ALU support, only the logical shift is legal
      3'b101: begin
        alu_control = ALU_SRL;
        legal       = ~funct7b5;
      end
      default: legal = 1'b0;
    endcase
  end

endmodule

`default_nettype wire

// File: rtl/multicycle_ctrl_fsm.sv
// ==========================================================================
// multicycle_ctrl_fsm: RV32I multicycle main control FSM (rev 1.0)
// ==========================================================================
`default_nettype none

module multicycle_ctrl_fsm
  import ctrl_pkg::*;
#(
  parameter bit RESET_STATE_FETCH = 1'b1
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       start,
  input  logic [6:0] op,
  input  logic [2:0] funct3,
  input  logic       funct7b5,
  input  logic       Zero_Flag,
  output logic       PCWrite,
  output logic       AdrSrc,
  output logic       MemWrite,
  output logic       IRWrite,
  output logic [1:0] ResultSrc,
  output logic [1:0] ALUSrcA,
  output logic [1:0] ALUSrcB,
  output logic [1:0] ImmSrc,
  output logic       RegWrite,
  output logic [2:0] ALU_Control,
  output logic       instr_retired,
  output logic       illegal_instr
);

  state_t     state;
  state_t     state_nxt;
  logic [2:0] func_alu;
  logic       func_legal;

  alu_func_decode u_func_decode (
    .op          (op),
    .funct3      (funct3),
    .funct7b5    (funct7b5),
    .alu_control (func_alu),
    .legal       (func_legal)
  );

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state         <= RESET_STATE_FETCH ? S_FETCH : S_IDLE;
      illegal_instr <= 1'b0;
    end else begin
      state <= state_nxt;
      if (state_nxt == S_TRAP) illegal_instr <= 1'b1;
    end
  end

  assign ImmSrc = imm_src_of(op);

  always_comb begin
    state_nxt     = state;
    PCWrite       = 1'b0;
    AdrSrc        = 1'b0;
    MemWrite      = 1'b0;
    IRWrite       = 1'b0;
    ResultSrc     = RES_ALUOUT;
    ALUSrcA       = SRCA_PC;
    ALUSrcB       = SRCB_RS2;
    RegWrite      = 1'b0;
    ALU_Control   = ALU_ADD;
    instr_retired = 1'b0;
    case (state)
      S_IDLE: if (start) state_nxt = S_FETCH;
      S_FETCH: begin
        IRWrite   = 1'b1;
        PCWrite   = 1'b1;
        ALUSrcB   = SRCB_FOUR;
        ResultSrc = RES_ALURESULT;
        state_nxt = S_DECODE;
      end
      S_DECODE: begin
        ALUSrcA = SRCA_OLDPC;
        ALUSrcB = SRCB_IMM;
        case (op)
          OP_LOAD, OP_STORE: state_nxt = S_MEMADR;
          OP_RTYPE:          state_nxt = S_EXECUTER;
          OP_ITYPE:          state_nxt = S_EXECUTEI;
          // only beq/bne have a matching PCWrite condition
          OP_BRANCH:         state_nxt = (funct3[2:1] == 2'b00) ? S_BRANCH : S_TRAP;
          OP_JAL:            state_nxt = S_JAL;
          default:           state_nxt = S_TRAP;
        endcase
      end
      S_MEMADR: begin
        ALUSrcA   = SRCA_RS1;
        ALUSrcB   = SRCB_IMM;
        state_nxt = (op == OP_STORE) ? S_MEMWRITE : S_MEMREAD;
      end
      S_MEMREAD: begin
        AdrSrc    = 1'b1;
        state_nxt = S_MEMWB;
      end
      S_MEMWB: begin
        ResultSrc     = RES_DATA;
        RegWrite      = 1'b1;
        instr_retired = 1'b1;
        state_nxt     = S_FETCH;
      end
      S_MEMWRITE: begin
        AdrSrc        = 1'b1;
        MemWrite      = 1'b1;
        instr_retired = 1'b1;
        state_nxt     = S_FETCH;
      end
      S_EXECUTER, S_EXECUTEI: begin
        ALUSrcA     = SRCA_RS1;
        ALUSrcB     = (state == S_EXECUTEI) ? SRCB_IMM : SRCB_RS2;
        ALU_Control = func_alu;
        state_nxt   = func_legal ? S_ALUWB : S_TRAP;
      end
      S_ALUWB: begin
        RegWrite      = 1'b1;
        instr_retired = 1'b1;
        state_nxt     = S_FETCH;
      end
      S_BRANCH: begin
        ALUSrcA       = SRCA_RS1;
        ALU_Control   = ALU_SUB;
        PCWrite       = Zero_Flag ^ funct3[0];
        instr_retired = 1'b1;
        state_nxt     = S_FETCH;
      end
      S_JAL: begin
        ALUSrcA   = SRCA_OLDPC;
        ALUSrcB   = SRCB_FOUR;
        PCWrite   = 1'b1;
        state_nxt = S_ALUWB;
      end
      S_TRAP:  state_nxt = S_TRAP;
      default: state_nxt = S_TRAP;
    endcase
  end

endmodule

`default_nettype wire

// File: tb/tb_multicycle_ctrl_fsm.sv
// ==========================================================================
// tb_multicycle_ctrl_fsm: randomized check against an instruction-level model
// ==========================================================================
`timescale 1ns/1ps
`default_nettype none

module tb_multicycle_ctrl_fsm;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       start = 1'b0;
  logic [6:0] op = 7'd0;
  logic [2:0] funct3 = 3'd0;
  logic       funct7b5 = 1'b0;
  logic       Zero_Flag = 1'b0;

  logic       PCWrite, AdrSrc, MemWrite, IRWrite, RegWrite, instr_retired, illegal_instr;
  logic [1:0] ResultSrc, ALUSrcA, ALUSrcB, ImmSrc;
  logic [2:0] ALU_Control;

  logic       idl_PCWrite, idl_AdrSrc, idl_MemWrite, idl_IRWrite, idl_RegWrite;
  logic       idl_instr_retired, idl_illegal_instr;
  logic [1:0] idl_ResultSrc, idl_ALUSrcA, idl_ALUSrcB, idl_ImmSrc;
  logic [2:0] idl_ALU_Control;

  int n_tests = 0;
  int n_fail  = 0;

  logic [15:0] exp_q[$];
  logic [15:0] msk_q[$];

  always #5 clk = ~clk;

  multicycle_ctrl_fsm #(.RESET_STATE_FETCH(1'b1)) u_dut (
    .clk(clk), .rst_n(rst_n), .start(start), .op(op), .funct3(funct3),
    .funct7b5(funct7b5), .Zero_Flag(Zero_Flag), .PCWrite(PCWrite), .AdrSrc(AdrSrc),
    .MemWrite(MemWrite), .IRWrite(IRWrite), .ResultSrc(ResultSrc), .ALUSrcA(ALUSrcA),
    .ALUSrcB(ALUSrcB), .ImmSrc(ImmSrc), .RegWrite(RegWrite), .ALU_Control(ALU_Control),
    .instr_retired(instr_retired), .illegal_instr(illegal_instr)
  );

  multicycle_ctrl_fsm #(.RESET_STATE_FETCH(1'b0)) u_dut_idle (
    .clk(clk), .rst_n(rst_n), .start(start), .op(op), .funct3(funct3),
    .funct7b5(funct7b5), .Zero_Flag(Zero_Flag), .PCWrite(idl_PCWrite), .AdrSrc(idl_AdrSrc),
    .MemWrite(idl_MemWrite), .IRWrite(idl_IRWrite), .ResultSrc(idl_ResultSrc),
    .ALUSrcA(idl_ALUSrcA), .ALUSrcB(idl_ALUSrcB), .ImmSrc(idl_ImmSrc),
    .RegWrite(idl_RegWrite), .ALU_Control(idl_ALU_Control),
    .instr_retired(idl_instr_retired), .illegal_instr(idl_illegal_instr)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %b expected %b", tag, got, exp);
    end
  endtask

  // {PCWrite, AdrSrc, MemWrite, IRWrite, ResultSrc, ALUSrcA, ALUSrcB, RegWrite, ALU_Control, retired, illegal}
  function automatic logic [15:0] mk(input logic pcw, input logic adr, input logic mw,
                                     input logic irw, input logic [1:0] rs, input logic [1:0] a,
                                     input logic [1:0] b, input logic rw, input logic [2:0] alu,
                                     input logic ret, input logic ill);
    return {pcw, adr, mw, irw, rs, a, b, rw, alu, ret, ill};
  endfunction

  function automatic logic [15:0] obs();
    return {PCWrite, AdrSrc, MemWrite, IRWrite, ResultSrc, ALUSrcA, ALUSrcB,
            RegWrite, ALU_Control, instr_retired, illegal_instr};
  endfunction

  function automatic logic [15:0] obs_idl();
    return {idl_PCWrite, idl_AdrSrc, idl_MemWrite, idl_IRWrite, idl_ResultSrc, idl_ALUSrcA,
            idl_ALUSrcB, idl_RegWrite, idl_ALU_Control, idl_instr_retired, idl_illegal_instr};
  endfunction

  function automatic logic [15:0] v_fetch();
    return mk(1, 0, 0, 1, 2'b10, 2'b00, 2'b10, 0, 3'd0, 0, 0);
  endfunction

  function automatic logic [2:0] ref_alu(input logic [6:0] o, input logic [2:0] f3,
                                         input logic f7, output bit ok);
    ok = 1'b1;
    case (f3)
      3'd0: return (o == 7'h33 && f7) ? 3'd1 : 3'd0;
      3'd7: return 3'd2;
      3'd6: return 3'd3;
      3'd4: return 3'd4;
      3'd1: return 3'd5;
      3'd2: return 3'd7;
      3'd5: begin ok = !f7; return 3'd6; end
      default: begin ok = 1'b0; return 3'd0; end
    endcase
  endfunction

  function automatic logic [1:0] ref_imm(input logic [6:0] o);
    case (o)
      7'h23:   return 2'd1;
      7'h63:   return 2'd2;
      7'h6F:   return 2'd3;
      default: return 2'd0;
    endcase
  endfunction

  task automatic push(input logic [15:0] v, input logic [15:0] m = 16'hFFFF);
    exp_q.push_back(v);
    msk_q.push_back(m);
  endtask

  // Expected per-cycle outputs for one instruction starting in FETCH
  task automatic build(input logic [6:0] o, input logic [2:0] f3, input logic f7,
                       input logic z, output bit trapped);
    bit          ok;
    logic [2:0]  alu;
    exp_q.delete();
    msk_q.delete();
    trapped = 1'b0;
    push(v_fetch());
    push(mk(0, 0, 0, 0, 2'b00, 2'b01, 2'b01, 0, 3'd0, 0, 0));
    case (o)
      7'h03: begin
        push(mk(0, 0, 0, 0, 2'b00, 2'b10, 2'b01, 0, 3'd0, 0, 0));
        push(mk(0, 1, 0, 0, 2'b00, 2'b00, 2'b00, 0, 3'd0, 0, 0));
        push(mk(0, 0, 0, 0, 2'b01, 2'b00, 2'b00, 1, 3'd0, 1, 0));
      end
      7'h23: begin
        push(mk(0, 0, 0, 0, 2'b00, 2'b10, 2'b01, 0, 3'd0, 0, 0));
        push(mk(0, 1, 1, 0, 2'b00, 2'b00, 2'b00, 0, 3'd0, 1, 0));
      end
      7'h33, 7'h13: begin
        alu = ref_alu(o, f3, f7, ok);
        push(mk(0, 0, 0, 0, 2'b00, 2'b10, (o == 7'h13) ? 2'b01 : 2'b00, 0, alu, 0, 0),
             ok ? 16'hFFFF : 16'hFFE3);
        if (ok) push(mk(0, 0, 0, 0, 2'b00, 2'b00, 2'b00, 1, 3'd0, 1, 0));
        else trapped = 1'b1;
      end
      7'h63: begin
        if (f3 == 3'd0 || f3 == 3'd1)
          push(mk(z ^ f3[0], 0, 0, 0, 2'b00, 2'b10, 2'b00, 0, 3'd1, 1, 0));
        else trapped = 1'b1;
      end
      7'h6F: begin
        push(mk(1, 0, 0, 0, 2'b00, 2'b01, 2'b10, 0, 3'd0, 0, 0));
        push(mk(0, 0, 0, 0, 2'b00, 2'b00, 2'b00, 1, 3'd0, 1, 0));
      end
      default: trapped = 1'b1;
    endcase
    if (trapped) repeat (3) push(mk(0, 0, 0, 0, 2'b00, 2'b00, 2'b00, 0, 3'd0, 0, 1));
  endtask

  task automatic do_reset(input string tag);
    rst_n = 1'b0;
    @(posedge clk); #2;
    @(posedge clk); #2;
    rst_n = 1'b1;
    check({tag, " reset"}, obs(), v_fetch());
  endtask

  // Entered and left at 2ns after a rising edge with the DUT in FETCH
  task automatic run_instr(input logic [6:0] o, input logic [2:0] f3, input logic f7,
                           input logic z, input string tag);
    bit trapped;
    op = o; funct3 = f3; funct7b5 = f7; Zero_Flag = z;
    build(o, f3, f7, z, trapped);
    #1;
    check({tag, " imm"}, 32'(ImmSrc), 32'(ref_imm(o)));
    foreach (exp_q[i]) begin
      if (i > 0) begin @(posedge clk); #2; end
      check($sformatf("%s c%0d", tag, i), obs() & msk_q[i], exp_q[i] & msk_q[i]);
    end
    if (trapped) do_reset(tag);
    else begin @(posedge clk); #2; end
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [6:0] ops[6];
    ops[0] = 7'h03; ops[1] = 7'h23; ops[2] = 7'h33;
    ops[3] = 7'h13; ops[4] = 7'h63; ops[5] = 7'h6F;

    do_reset("init");
    check("idle rst", 32'(obs_idl()), 32'd0);
    @(posedge clk); #2;
    check("idle hold", 32'(obs_idl()), 32'd0);
    start = 1'b1;
    @(posedge clk); #2;
    start = 1'b0;
    check("idle start", 32'(obs_idl()), 32'(v_fetch()));
    do_reset("post idle");

    run_instr(7'h03, 3'd2, 1'b0, 1'b0, "lw");
    run_instr(7'h23, 3'd2, 1'b0, 1'b0, "sw");
    run_instr(7'h33, 3'd0, 1'b1, 1'b0, "sub");
    run_instr(7'h13, 3'd0, 1'b1, 1'b0, "addi f7");
    run_instr(7'h63, 3'd0, 1'b0, 1'b1, "beq z1");
    run_instr(7'h63, 3'd1, 1'b0, 1'b1, "bne z1");
    run_instr(7'h6F, 3'd0, 1'b0, 1'b0, "jal");
    run_instr(7'h00, 3'd0, 1'b0, 1'b0, "illegal op");
    run_instr(7'h33, 3'd5, 1'b1, 1'b0, "sra");
    run_instr(7'h13, 3'd3, 1'b0, 1'b0, "sltiu");
    run_instr(7'h63, 3'd4, 1'b0, 1'b0, "blt");

    op = 7'h23; funct3 = 3'd2; funct7b5 = 1'b0;
    @(posedge clk); #2;
    @(posedge clk); #2;
    check("abort memadr", obs(), mk(0, 0, 0, 0, 2'b00, 2'b10, 2'b01, 0, 3'd0, 0, 0));
    rst_n = 1'b0;
    @(posedge clk); #2;
    check("abort fetch", obs(), v_fetch());
    check("abort memwrite", 32'(MemWrite), 32'd0);
    rst_n = 1'b1;
    run_instr(7'h23, 3'd2, 1'b0, 1'b0, "sw resumed");

    for (int n = 0; n < 80; n++) begin
      logic [6:0] o;
      int         k;
      k = $urandom_range(0, 7);
      o = (k < 6) ? ops[k] : 7'($urandom);
      run_instr(o, 3'($urandom), 1'($urandom), 1'($urandom), $sformatf("rnd%0d op%h", n, o));
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

`default_nettype wire
